// File: rtl/ps_folded_if.sv
// Handshake bundle for the folded Ascon substitution layer.
// A state is five 64-bit words packed as {x0, x1, x2, x3, x4}, so x0 sits at index 4.
interface ps_folded_if;
  logic             start_i;
  logic [4:0][63:0] psin_i;
  logic             ready_o;
  logic             valid_o;
  logic [4:0][63:0] psout_o;

  modport slave  (input start_i, psin_i, output ready_o, valid_o, psout_o);
  modport master (output start_i, psin_i, input ready_o, valid_o, psout_o);
endinterface

// File: rtl/ps_folded.sv
// Folded Ascon S-box layer: LANES bit-columns are substituted per clock.
// After each slice the words rotate right by LANES, so 64/LANES steps restore the original bit order.
module ps_folded #(
  parameter int LANES = 16
) (
  input logic        clock_i,
  input logic        reset_i,
  ps_folded_if.slave bus
);
  localparam int NCYC = 64 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [4:0][63:0] r_work;
  logic [4:0][63:0] r_psout;
  logic             r_ready;
  logic             r_valid;

  logic [4:0][LANES-1:0] w_slice;
  logic [4:0][LANES-1:0] w_sub;
  logic [4:0][63:0]      w_next;

  // Ascon chi/xor network, applied bit-parallel to LANES columns; x0 is word index 4.
  function automatic logic [4:0][LANES-1:0] sbox_slice(input logic [4:0][LANES-1:0] x);
    logic [LANES-1:0] a0, a1, a2, a3, a4;
    logic [LANES-1:0] t0, t1, t2, t3, t4;
    a0 = x[4] ^ x[0];
    a1 = x[3];
    a2 = x[2] ^ x[3];
    a3 = x[1];
    a4 = x[0] ^ x[1];
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    return {a0, a1, a2, a3, a4};
  endfunction

  // Overwrite the low LANES bits with the substituted slice, then rotate right by LANES.
  function automatic logic [63:0] place_rot(input logic [63:0] w, input logic [LANES-1:0] s);
    logic [63:0] m;
    logic [63:0] r;
    m = w;
    for (int b = 0; b < LANES; b++) m[b] = s[b];
    for (int b = 0; b < 64; b++) r[b] = m[(b + LANES) % 64];
    return r;
  endfunction

  always_comb begin
    w_slice = '0;
    w_next  = '0;
    for (int i = 0; i < 5; i++) w_slice[i] = r_work[i][LANES-1:0];
    w_sub = sbox_slice(w_slice);
    for (int i = 0; i < 5; i++) w_next[i] = place_rot(r_work[i], w_sub[i]);
  end

  // DONE also accepts a new start so back-to-back operations run every NCYC+1 cycles.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_psout <= '0;
      r_cnt   <= '0;
      r_work  <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_work  <= bus.psin_i;
            r_cnt   <= '0;
            r_state <= RUN;
            r_ready <= 1'b0;
          end
        end
        RUN: begin
          r_work <= w_next;
          if (r_cnt == CW'(NCYC - 1)) begin
            r_state <= DONE;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_psout <= r_work;
          r_valid <= 1'b1;
          if (bus.start_i) begin
            r_work  <= bus.psin_i;
            r_cnt   <= '0;
            r_state <= RUN;
            r_ready <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_o = r_ready;
  assign bus.valid_o = r_valid;
  assign bus.psout_o = r_psout;
endmodule
